// File: rtl/spectrum_frame_buffer.sv
// Ping-pong magnitude frame store between the FFT magnitude stage and the
// display/peak-search reader. One bank captures a full frame while the other
// bank is offered as a backpressured read stream. Banks swap only on frame
// boundaries, so the reader never sees a torn frame.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_data/addr    magnitude sample and its bin index, qualified by wr_valid
//   rd_start        request readout of the available frame
//   rd_ready        consumer ready
//   rd_data/addr    current read beat, qualified by rd_valid; rd_last on bin N-1
//   frame_avail     a completed, unread frame sits in the read bank
//   rd_busy         readout in progress
//   frames_dropped  saturating count of input frames discarded while held off
module spectrum_frame_buffer #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_valid,
    input  logic              rd_start,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              frame_avail,
    output logic              rd_busy,
    output logic [7:0]        frames_dropped
);

    localparam int unsigned N = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

    typedef enum logic [1:0] {WR_SYNC, WR_ACTIVE, WR_HOLD} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;

    wr_state_t wr_state, wr_state_nxt;
    rd_state_t rd_state, rd_state_nxt;

    logic [DATA_W-1:0] mem [0:(2*N)-1];
    logic [DATA_W-1:0] ram_q;
    logic              wr_bank;

    logic [ADDR_W-1:0] issue_ptr;
    logic              issue_done;
    logic              ram_v;
    logic [ADDR_W-1:0] ram_addr;

    logic mem_we;
    logic swap;
    logic drop;
    logic rd_idle;
    logic rd_accept;
    logic wr_first;
    logic wr_final;
    logic out_en;
    logic ram_en;
    logic issue;
    logic last_xfer;

    assign rd_idle   = (rd_state == RD_IDLE);
    assign rd_accept = rd_idle && rd_start && frame_avail;
    assign wr_first  = wr_valid && (wr_addr == '0);
    assign wr_final  = wr_valid && (wr_addr == LAST_ADDR);

    // Read pipeline: issue address -> RAM register -> output register.
    // Each stage advances only when the stage after it can take the beat,
    // so the RAM register doubles as the hold register during stalls.
    assign out_en    = !rd_valid || rd_ready;
    assign ram_en    = !ram_v || out_en;
    assign issue     = (rd_state == RD_RUN) && !issue_done && ram_en;
    assign last_xfer = rd_valid && rd_ready && rd_last;

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= WR_SYNC;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
        end
    end

    // Next-state and control strobes for both FSMs
    always_comb begin
        wr_state_nxt = wr_state;
        rd_state_nxt = rd_state;
        mem_we       = 1'b0;
        swap         = 1'b0;
        drop         = 1'b0;

        case (wr_state)
            WR_SYNC: begin
                if (wr_first) begin
                    mem_we       = 1'b1;
                    wr_state_nxt = WR_ACTIVE;
                end
            end
            WR_ACTIVE: begin
                mem_we = wr_valid;
                if (wr_final) begin
                    // A readout starting this cycle owns the old bank; defer.
                    if (rd_idle && !rd_accept) swap = 1'b1;
                    else                       wr_state_nxt = WR_HOLD;
                end
            end
            WR_HOLD: begin
                drop = wr_first;
                if (rd_idle && !rd_accept) begin
                    swap         = 1'b1;
                    wr_state_nxt = WR_SYNC;
                end
            end
            default: wr_state_nxt = WR_SYNC;
        endcase

        case (rd_state)
            RD_IDLE: if (rd_accept) rd_state_nxt = RD_RUN;
            RD_RUN:  if (last_xfer) rd_state_nxt = RD_IDLE;
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    // Frame bookkeeping and read pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank        <= 1'b0;
            frame_avail    <= 1'b0;
            rd_busy        <= 1'b0;
            frames_dropped <= 8'd0;
            issue_ptr      <= '0;
            issue_done     <= 1'b0;
            ram_v          <= 1'b0;
            ram_addr       <= '0;
            rd_valid       <= 1'b0;
            rd_data        <= '0;
            rd_addr        <= '0;
            rd_last        <= 1'b0;
        end else begin
            if (swap) begin
                wr_bank     <= ~wr_bank;
                frame_avail <= 1'b1;
            end else if (rd_accept) begin
                frame_avail <= 1'b0;
            end

            if (drop && (frames_dropped != 8'hFF))
                frames_dropped <= frames_dropped + 8'd1;

            if (rd_accept)      rd_busy <= 1'b1;
            else if (last_xfer) rd_busy <= 1'b0;

            if (rd_accept) begin
                issue_ptr  <= '0;
                issue_done <= 1'b0;
            end else if (issue) begin
                issue_ptr <= issue_ptr + ADDR_W'(1);
                if (issue_ptr == LAST_ADDR) issue_done <= 1'b1;
            end

            if (ram_en) begin
                ram_v    <= issue;
                ram_addr <= issue_ptr;
            end

            if (out_en) begin
                rd_valid <= ram_v;
                rd_last  <= ram_v && (ram_addr == LAST_ADDR);
                if (ram_v) begin
                    rd_data <= ram_q;
                    rd_addr <= ram_addr;
                end
            end
        end
    end

    // Frame RAM: contents are not reset; read port is ~wr_bank, which is
    // stable for the whole readout because swaps only happen while idle.
    always_ff @(posedge clk) begin
        if (mem_we) mem[{wr_bank, wr_addr}] <= wr_data;
        if (ram_en) ram_q <= mem[{~wr_bank, issue_ptr}];
    end

endmodule

// File: tb/tb_spectrum_frame_buffer.sv
// Self-checking bench for spectrum_frame_buffer (ADDR_W=4, N=16).
// Expected read beats are queued when a readout is requested and compared
// by a monitor as transfers occur.
module tb_spectrum_frame_buffer;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned N      = 16;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_valid;
    logic              rd_start;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic              rd_last;
    logic              frame_avail;
    logic              rd_busy;
    logic [7:0]        frames_dropped;

    spectrum_frame_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_data        (wr_data),
        .wr_addr        (wr_addr),
        .wr_valid       (wr_valid),
        .rd_start       (rd_start),
        .rd_ready       (rd_ready),
        .rd_data        (rd_data),
        .rd_addr        (rd_addr),
        .rd_valid       (rd_valid),
        .rd_last        (rd_last),
        .frame_avail    (frame_avail),
        .rd_busy        (rd_busy),
        .frames_dropped (frames_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    xfers    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int base);
        beat_t b;
        for (int i = 0; i < int'(N); i++) begin
            b.data = 16'(base + i);
            b.addr = 4'(i);
            b.last = (i == int'(N) - 1);
            sb.push_back(b);
        end
    endtask

    task automatic write_range(input int base, input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            wr_valid = 1'b1;
            wr_addr  = 4'(a);
            wr_data  = 16'(base + a);
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_data"},  32'(rd_data), 0);
        check({tag, "_rd_addr"},  32'(rd_addr), 0);
        check({tag, "_rd_valid"}, 32'(rd_valid), 0);
        check({tag, "_rd_last"},  32'(rd_last), 0);
        check({tag, "_avail"},    32'(frame_avail), 0);
        check({tag, "_busy"},     32'(rd_busy), 0);
        check({tag, "_dropped"},  32'(frames_dropped), 0);
    endtask

    // Drives rd_ready from a 4-cycle pattern (bit 0 first) until rd_busy falls.
    // Returns just after the edge that ended the readout.
    task automatic run_readout(input logic [3:0] pat, input bit do_start);
        int x0;
        bit done;
        x0   = xfers;
        done = 1'b0;
        if (do_start) rd_start = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            rd_ready = pat[2'(c % 4)];
            tick();
            rd_start = 1'b0;
            if (!rd_busy) done = 1'b1;
        end
        rd_ready = 1'b1;
        check("readout_done", 32'(done), 1);
        check("xfer_count", 32'(xfers - x0), 16);
        check("sb_drained", 32'(sb.size()), 0);
    endtask

    // Scoreboard monitor: transfers and stall stability sampled on negedge.
    logic              stall_prev;
    logic [DATA_W-1:0] held_data;
    logic [ADDR_W-1:0] held_addr;
    logic              held_last;

    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 32'(rd_valid), 1);
                check("stall_data",  32'(rd_data), 32'(held_data));
                check("stall_addr",  32'(rd_addr), 32'(held_addr));
                check("stall_last",  32'(rd_last), 32'(held_last));
            end
            if (rd_valid && rd_ready) begin
                xfers++;
                if (sb.size() == 0) begin
                    check("unexpected_beat", 32'(sb.size()), 1);
                end else begin
                    b = sb.pop_front();
                    check("beat_data", 32'(rd_data), 32'(b.data));
                    check("beat_addr", 32'(rd_addr), 32'(b.addr));
                    check("beat_last", 32'(rd_last), 32'(b.last));
                end
            end
            stall_prev = rd_valid && !rd_ready;
            held_data  = rd_data;
            held_addr  = rd_addr;
            held_last  = rd_last;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_start = 1'b0;
        rd_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();
        check_outputs_zero("post_reset");

        // Frame A: leading bins 5..15 discarded until bin 0 is seen
        write_range(100, 5, 15);
        check("sync_discard_avail", 32'(frame_avail), 0);
        write_range(100, 0, 14);
        check("partial_avail", 32'(frame_avail), 0);
        write_range(100, 15, 15);
        check("avail_after_last_write", 32'(frame_avail), 1);
        check("busy_idle", 32'(rd_busy), 0);

        // Readout with 2-cycle start latency
        push_frame(100);
        rd_start = 1'b1;
        rd_ready = 1'b1;
        tick();
        rd_start = 1'b0;
        check("start_busy", 32'(rd_busy), 1);
        check("start_avail_clr", 32'(frame_avail), 0);
        check("start_valid_c0", 32'(rd_valid), 0);
        tick();
        check("start_valid_c1", 32'(rd_valid), 0);
        tick();
        check("start_valid_c2", 32'(rd_valid), 1);
        run_readout(4'b1111, 1'b0);
        tick();
        check("valid_drops_after_last", 32'(rd_valid), 0);

        // rd_start without an available frame is ignored
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        check("start_no_frame_busy", 32'(rd_busy), 0);

        // Backpressured readout, ready pattern 1,0,0,1
        write_range(200, 0, 15);
        check("frame2_avail", 32'(frame_avail), 1);
        push_frame(200);
        run_readout(4'b1001, 1'b1);
        check("bp_busy_clear", 32'(rd_busy), 0);

        // Frame B completes during stalled readout of A; frame C dropped
        write_range(300, 0, 15);
        push_frame(300);
        rd_start = 1'b1;
        rd_ready = 1'b0;
        tick();
        rd_start = 1'b0;
        write_range(400, 0, 15);
        write_range(500, 0, 15);
        for (int i = 0; i < 8; i++) tick();
        check("hold_dropped", 32'(frames_dropped), 1);
        check("hold_avail", 32'(frame_avail), 0);
        check("hold_busy", 32'(rd_busy), 1);
        check("hold_valid", 32'(rd_valid), 1);
        run_readout(4'b1111, 1'b0);
        check("deferred_avail_edge0", 32'(frame_avail), 0);
        tick();
        check("deferred_avail_edge1", 32'(frame_avail), 1);
        push_frame(400);
        run_readout(4'b1111, 1'b1);

        // Completion coincides with rd_start acceptance
        write_range(600, 0, 15);
        check("x_avail", 32'(frame_avail), 1);
        write_range(700, 0, 14);
        push_frame(600);
        wr_valid = 1'b1;
        wr_addr  = 4'(15);
        wr_data  = 16'(715);
        rd_start = 1'b1;
        rd_ready = 1'b1;
        tick();
        wr_valid = 1'b0;
        rd_start = 1'b0;
        check("coincide_busy", 32'(rd_busy), 1);
        check("coincide_avail", 32'(frame_avail), 0);
        run_readout(4'b1111, 1'b0);
        check("coincide_avail_edge0", 32'(frame_avail), 0);
        tick();
        check("coincide_avail_edge1", 32'(frame_avail), 1);
        push_frame(700);
        run_readout(4'b1111, 1'b1);

        // Reset mid-readout at beat 7
        write_range(800, 0, 15);
        push_frame(800);
        rd_start = 1'b1;
        rd_ready = 1'b1;
        tick();
        rd_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (rd_valid && rd_addr == 4'(7)) found = 1'b1;
            else tick();
        end
        check("reach_beat7", 32'(found), 1);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        sb.delete();
        tick();
        rst = 1'b0;
        tick();
        check_outputs_zero("after_mid_reset");
        rd_start = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rd_start = 1'b0;
        check("ignored_start_busy", 32'(rd_busy), 0);
        check("ignored_start_valid", 32'(rd_valid), 0);
        write_range(850, 3, 15);
        check("nonfresh_avail", 32'(frame_avail), 0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        tick();
        check("nonfresh_busy", 32'(rd_busy), 0);
        check("nonfresh_valid", 32'(rd_valid), 0);
        write_range(900, 0, 15);
        check("fresh_avail", 32'(frame_avail), 1);
        push_frame(900);
        run_readout(4'b1111, 1'b1);

        // Drop counter saturation
        write_range(1000, 0, 15);
        push_frame(1000);
        rd_start = 1'b1;
        rd_ready = 1'b0;
        tick();
        rd_start = 1'b0;
        write_range(1100, 0, 15);
        for (int f = 0; f < 300; f++) begin
            write_range(1200, 0, 15);
            if (f == 253) check("dropped_254", 32'(frames_dropped), 254);
        end
        check("dropped_saturated", 32'(frames_dropped), 255);
        run_readout(4'b1111, 1'b0);
        tick();
        check("sat_avail", 32'(frame_avail), 1);
        push_frame(1100);
        run_readout(4'b1111, 1'b1);
        check("dropped_hold_255", 32'(frames_dropped), 255);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
